mux_sel_seq: RTL and testbench

MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

---
 rtl/mux_sel_seq.sv | 176 +++++++++++++++++
 tb/tb_mux_sel_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_seq.sv
// rtl/mux_sel_seq.sv - channel-scanning select sequencer for a downstream 4:1 mux
//
// Purpose: after start, steps {sel1,sel0} through the channels enabled in
// ch_mask. Each channel is held for DWELL cycles. The final dwell cycle of
// each channel is flagged with sample, and the final cycle of each sweep is
// also flagged with sweep_done.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   oneshot     (only with MUX_SEL_SEQ_ONESHOT_EN) latched with start; stop after one sweep
//   start       level request to begin scanning, honoured only when idle
//   stop        abort scanning, honoured in any state
//   ch_mask     channel enables, bit n enables mux input n
//   sel1/sel0   registered mux select MSB/LSB
//   busy        high while scanning
//   sample      strobe on the final dwell cycle of each channel
//   sweep_done  strobe on the final dwell cycle of the last channel before wrap
//
// Optional feature macro: MUX_SEL_SEQ_ONESHOT_EN
//
// Every output is a flop. sample/sweep_done are therefore computed one cycle
// ahead from the next-state values. sweep_done uses the ch_mask seen on the
// edge that enters the final dwell cycle. The channel advance uses the ch_mask
// seen on the edge that leaves that cycle.

module mux_sel_seq #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MUX_SEL_SEQ_ONESHOT_EN
  input  logic       oneshot,
`endif
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] ch_mask,
  output logic       sel1,
  output logic       sel0,
  output logic       busy,
  output logic       sample,
  output logic       sweep_done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       sample_q, sample_d;
  logic       sweep_q, sweep_d;
  logic       os_q;

  // Lowest enabled channel; used when a scan starts.
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    casez (m)
      4'b???1: lowest_ch = 2'd0;
      4'b??10: lowest_ch = 2'd1;
      4'b?100: lowest_ch = 2'd2;
      default: lowest_ch = 2'd3;
    endcase
  endfunction

  // Next enabled channel above cur, wrapping 3->0. cur itself is tried last.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] c1, c2, c3;
    c1 = cur + 2'd1;
    c2 = cur + 2'd2;
    c3 = cur + 2'd3;
    if (m[c1])      next_ch = c1;
    else if (m[c2]) next_ch = c2;
    else if (m[c3]) next_ch = c3;
    else            next_ch = cur;
  endfunction

  // True when no enabled channel sits above cur, so the next advance wraps.
  // This also holds for an empty mask, which ends the scan with sweep_done.
  function automatic logic none_above(input logic [1:0] cur, input logic [3:0] m);
    none_above = ~|(m & (4'b1110 << cur));
  endfunction

`ifdef MUX_SEL_SEQ_ONESHOT_EN
  logic os_d;
`else
  assign os_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
`ifdef MUX_SEL_SEQ_ONESHOT_EN
    os_d    = os_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop && (ch_mask != 4'b0000)) begin
          state_d = SCAN;
          cnt_d   = 8'd0;
          sel_d   = lowest_ch(ch_mask);
`ifdef MUX_SEL_SEQ_ONESHOT_EN
          os_d    = oneshot;
`endif
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          sel_d   = 2'd0;
        end else if (cnt_q == LAST) begin
          cnt_d = 8'd0;
          // sweep_q is high in this cycle exactly when this advance wraps.
          if ((ch_mask == 4'b0000) || (os_q && sweep_q)) begin
            state_d = IDLE;
            sel_d   = 2'd0;
          end else begin
            sel_d = next_ch(sel_q, ch_mask);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        sel_d   = 2'd0;
      end
    endcase

    busy_d   = (state_d == SCAN);
    sample_d = (state_d == SCAN) && (cnt_d == LAST);
    sweep_d  = sample_d && none_above(sel_d, ch_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      sample_q <= 1'b0;
      sweep_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      sweep_q  <= sweep_d;
    end
  end

`ifdef MUX_SEL_SEQ_ONESHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_q <= 1'b0;
    end else begin
      os_q <= os_d;
    end
  end
`endif

  assign sel1       = sel_q[1];
  assign sel0       = sel_q[0];
  assign busy       = busy_q;
  assign sample     = sample_q;
  assign sweep_done = sweep_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// tb/tb_mux_sel_seq.sv - randomized and directed bench for mux_sel_seq against a behavioural model

module tb_mux_sel_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef MUX_SEL_SEQ_ONESHOT_EN
  localparam bit HAS_OS = 1'b1;
`else
  localparam bit HAS_OS = 1'b0;
`endif

  // Instance 0: DWELL=4, instance 1: DWELL=1
  logic       start0 = 1'b0, stop0 = 1'b0, os0 = 1'b0;
  logic [3:0] mask0 = 4'b0000;
  logic       start1 = 1'b0, stop1 = 1'b0, os1 = 1'b0;
  logic [3:0] mask1 = 4'b0000;
  logic       d0_sel1, d0_sel0, d0_busy, d0_sample, d0_sweep;
  logic       d1_sel1, d1_sel0, d1_busy, d1_sample, d1_sweep;

  mux_sel_seq #(.DWELL(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX_SEL_SEQ_ONESHOT_EN
    .oneshot(os0),
`endif
    .start(start0), .stop(stop0), .ch_mask(mask0),
    .sel1(d0_sel1), .sel0(d0_sel0), .busy(d0_busy),
    .sample(d0_sample), .sweep_done(d0_sweep)
  );

  mux_sel_seq #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX_SEL_SEQ_ONESHOT_EN
    .oneshot(os1),
`endif
    .start(start1), .stop(stop1), .ch_mask(mask1),
    .sel1(d1_sel1), .sel0(d1_sel0), .busy(d1_busy),
    .sample(d1_sample), .sweep_done(d1_sweep)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per instance, scanning flag, current channel and
  // position within the dwell of that channel.
  int m_scan[2];
  int m_chan[2];
  int m_pos[2];
  int m_os[2];
  int dwell[2] = '{4, 1};

  // First enabled channel met when walking upward from 'from', wrapping mod 4; -1 if none.
  function automatic int first_from(input int from, input logic [3:0] m);
    first_from = -1;
    for (int k = 3; k >= 0; k--)
      if (m[(from + k) % 4]) first_from = (from + k) % 4;
  endfunction

  function automatic bit wraps(input int chan, input logic [3:0] m);
    wraps = (m == 4'b0000) || (first_from(chan + 1, m) <= chan);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_scan[i] = 0; m_chan[i] = 0; m_pos[i] = 0; m_os[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic s, input logic p, input logic [3:0] m, input logic os);
    if (m_scan[i] == 0) begin
      if (s && !p && m != 4'b0000) begin
        m_scan[i] = 1;
        m_chan[i] = first_from(0, m);
        m_pos[i]  = 0;
        m_os[i]   = HAS_OS ? int'(os) : 0;
      end
    end else if (p) begin
      m_scan[i] = 0; m_chan[i] = 0; m_pos[i] = 0;
    end else if (m_pos[i] == dwell[i] - 1) begin
      m_pos[i] = 0;
      if (m == 4'b0000 || (m_os[i] != 0 && wraps(m_chan[i], m))) begin
        m_scan[i] = 0; m_chan[i] = 0;
      end else begin
        m_chan[i] = first_from(m_chan[i] + 1, m);
      end
    end else begin
      m_pos[i] = m_pos[i] + 1;
    end
  endtask

  function automatic bit exp_sample(input int i);
    exp_sample = (m_scan[i] != 0) && (m_pos[i] == dwell[i] - 1);
  endfunction

  task automatic check_all();
    check("d0_sel",    {6'b0, d0_sel1, d0_sel0}, 8'(m_chan[0]));
    check("d0_busy",   {7'b0, d0_busy},   8'(m_scan[0]));
    check("d0_sample", {7'b0, d0_sample}, {7'b0, exp_sample(0)});
    check("d0_sweep",  {7'b0, d0_sweep},  {7'b0, exp_sample(0) && wraps(m_chan[0], mask0)});
    check("d1_sel",    {6'b0, d1_sel1, d1_sel0}, 8'(m_chan[1]));
    check("d1_busy",   {7'b0, d1_busy},   8'(m_scan[1]));
    check("d1_sample", {7'b0, d1_sample}, {7'b0, exp_sample(1)});
    check("d1_sweep",  {7'b0, d1_sweep},  {7'b0, exp_sample(1) && wraps(m_chan[1], mask1)});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d0"}, {3'b0, d0_sel1, d0_sel0, d0_busy, d0_sample, d0_sweep}, 8'd0);
    check({tag, "_d1"}, {3'b0, d1_sel1, d1_sel0, d1_busy, d1_sample, d1_sweep}, 8'd0);
  endtask

  task automatic cyc(input logic s0, input logic p0, input logic [3:0] m0,
                     input logic s1, input logic p1, input logic [3:0] m1);
    start0 = s0; stop0 = p0; mask0 = m0;
    start1 = s1; stop1 = p1; mask1 = m1;
    @(posedge clk);
    model_step(0, start0, stop0, mask0, os0);
    model_step(1, start1, stop1, mask1, os1);
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc0(input logic s, input logic p, input logic [3:0] m);
    cyc(s, p, m, 1'b0, 1'b0, mask1);
  endtask

  task automatic cyc1(input logic s, input logic p, input logic [3:0] m);
    cyc(1'b0, 1'b0, mask0, s, p, m);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    // Full mask sweep: four channels of four cycles, then wrap to channel 0
    cyc0(1'b1, 1'b0, 4'b1111);
    for (int n = 0; n < 17; n++) cyc0(1'b0, 1'b0, 4'b1111);
    cyc0(1'b0, 1'b1, 4'b1111);

    // Sparse mask 1010, then single-channel mask 0100
    cyc0(1'b1, 1'b0, 4'b1010);
    for (int n = 0; n < 20; n++) cyc0(1'b0, 1'b0, 4'b1010);
    cyc0(1'b0, 1'b1, 4'b1010);
    cyc0(1'b1, 1'b0, 4'b0100);
    for (int n = 0; n < 12; n++) cyc0(1'b0, 1'b0, 4'b0100);
    cyc0(1'b0, 1'b1, 4'b0100);

    // Mask emptied mid-dwell: last sample/sweep_done emitted, then idle
    cyc0(1'b1, 1'b0, 4'b0001);
    for (int n = 0; n < 5; n++) cyc0(1'b0, 1'b0, 4'b0000);

    // Stop at cnt=2 on channel 1
    cyc0(1'b1, 1'b0, 4'b1111);
    for (int n = 0; n < 6; n++) cyc0(1'b0, 1'b0, 4'b1111);
    cyc0(1'b0, 1'b1, 4'b1111);
    check("stop_state", {5'b0, d0_sel1, d0_sel0, d0_busy, d0_sample}, 8'd0);
    cyc0(1'b1, 1'b0, 4'b0000);
    cyc0(1'b1, 1'b1, 4'b1111);
    check("start_stop_idle", {7'b0, d0_busy}, 8'd0);

    // Asynchronous reset mid-dwell on channel 2
    cyc0(1'b1, 1'b0, 4'b1111);
    for (int n = 0; n < 9; n++) cyc0(1'b0, 1'b0, 4'b1111);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc0(1'b1, 1'b0, 4'b1111);
    for (int n = 0; n < 6; n++) cyc0(1'b0, 1'b0, 4'b1111);
    cyc0(1'b0, 1'b1, 4'b1111);

    // DWELL=1 full mask: channel changes and sample every cycle
    cyc1(1'b1, 1'b0, 4'b1111);
    for (int n = 0; n < 10; n++) cyc1(1'b0, 1'b0, 4'b1111);
    cyc1(1'b0, 1'b1, 4'b1111);

    // Oneshot: one sweep only (behaves as continuous when the port is absent)
    os0 = 1'b1; os1 = 1'b1;
    cyc(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1011);
    for (int n = 0; n < 20; n++) cyc(1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1011);
    cyc(1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b1011);
    os0 = 1'b0; os1 = 1'b0;

    // Random phase. Instance 0 never changes mask across the edge that ends
    // a final dwell cycle and is never stopped in that cycle; instance 1
    // (every cycle final) keeps its mask fixed while scanning.
    for (int n = 0; n < 2000; n++) begin
      logic s0, p0, s1, p1;
      logic [3:0] m0, m1;
      bit fin0;
      fin0 = (m_scan[0] != 0) && (m_pos[0] == dwell[0] - 1);
      s0 = ($urandom % 6) == 0;
      p0 = (($urandom % 50) == 0) && !fin0;
      m0 = mask0;
      if (!fin0 && (($urandom % 5) == 0)) m0 = 4'($urandom);
      s1 = ($urandom % 6) == 0;
      p1 = ($urandom % 25) == 0;
      m1 = mask1;
      if ((m_scan[1] == 0) && (($urandom % 3) == 0)) m1 = 4'($urandom);
      os0 = 1'($urandom);
      os1 = 1'($urandom);
      cyc(s0, p0, m0, s1, p1, m1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
